// File: rtl/pent_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pent_ram_arbiter_if
//  Description : Video, CPU and RAM-pin bundle around the main-RAM slot arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pent_ram_arbiter_if #(
    parameter int ADDR_W = 19
);
    logic              grp_start;
    logic              vid_active;
    logic [ADDR_W-1:0] vid_pix_addr;
    logic [ADDR_W-1:0] vid_attr_addr;
    logic [7:0]        vid_pix;
    logic [7:0]        vid_attr;
    logic              vid_strobe;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;
    logic [ADDR_W-1:0] ma;
    logic [7:0]        md_in;
    logic [7:0]        md_out;
    logic              md_oe;
    logic              cs_n;
    logic              we_n;

    // Arbiter side.
    modport slave (
        input  grp_start, vid_active, vid_pix_addr, vid_attr_addr,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, md_in,
        output vid_pix, vid_attr, vid_strobe, cpu_rdata, cpu_ack,
               ma, md_out, md_oe, cs_n, we_n
    );

    // Video timing, CPU decode and RAM side.
    modport master (
        output grp_start, vid_active, vid_pix_addr, vid_attr_addr,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, md_in,
        input  vid_pix, vid_attr, vid_strobe, cpu_rdata, cpu_ack,
               ma, md_out, md_oe, cs_n, we_n
    );
endinterface
`default_nettype wire

// File: rtl/pent_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pent_ram_arbiter
//  Description : 16-clock slot scheduler sharing main SRAM between video and CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module pent_ram_arbiter #(
    parameter int ADDR_W = 19
) (
    input  logic              clk14m,
    input  logic              rst,
    pent_ram_arbiter_if.slave bus
);

    localparam logic [1:0] c_PH_ADDR = 2'd0;
    localparam logic [1:0] c_PH_STB1 = 2'd1;
    localparam logic [1:0] c_PH_STB2 = 2'd2;
    localparam logic [1:0] c_PH_DONE = 2'd3;

    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_pending;
    logic              w_pending_nxt;
    logic [1:0]        w_phase;
    logic [1:0]        w_slot;

    logic              r_vid_grp;
    logic              r_holdoff;
    logic              r_busy;
    logic              r_is_cpu;
    logic              r_is_wr;
    logic              r_is_attr;

    logic              w_vid_slot;
    logic              w_vid_start;
    logic              w_cpu_start;
    logic [ADDR_W-1:0] w_vid_addr;

    logic [ADDR_W-1:0] r_ma;
    logic [7:0]        r_md_out;
    logic              r_md_oe;
    logic              r_cs_n;
    logic              r_we_n;
    logic [7:0]        r_cpu_rdata;
    logic              r_cpu_ack;
    logic [7:0]        r_vid_pix;
    logic [7:0]        r_vid_attr;
    logic              r_vid_strobe;

    assign w_phase = r_cnt[1:0];
    assign w_slot  = r_cnt[3:2];

    // ------------------------------------------------------------------
    // Slot counter state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk14m) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_pending <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Realignment only ever lands on a slot boundary, so no access is cut short.
    always_comb begin
        w_cnt_nxt     = r_cnt + 4'd1;
        w_pending_nxt = r_pending;
        if (w_phase == c_PH_DONE) begin
            if (bus.grp_start || r_pending) begin
                w_cnt_nxt = 4'd0;
            end
            w_pending_nxt = 1'b0;
        end else if (bus.grp_start) begin
            w_pending_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Slot ownership decode at phase 0
    // ------------------------------------------------------------------
    always_comb begin
        w_vid_slot = 1'b0;
        case (w_slot)
            2'd0:    w_vid_slot = bus.vid_active;
            2'd1:    w_vid_slot = r_vid_grp;
            default: w_vid_slot = 1'b0;
        endcase
        w_vid_start = (w_phase == c_PH_ADDR) && w_vid_slot;
        w_cpu_start = (w_phase == c_PH_ADDR) && !w_vid_slot && bus.cpu_req && !r_holdoff;
        w_vid_addr  = (w_slot == 2'd0) ? bus.vid_pix_addr : bus.vid_attr_addr;
    end

    // ------------------------------------------------------------------
    // Access sequencer and registered RAM/port outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk14m) begin
        if (rst) begin
            r_vid_grp    <= 1'b0;
            r_holdoff    <= 1'b0;
            r_busy       <= 1'b0;
            r_is_cpu     <= 1'b0;
            r_is_wr      <= 1'b0;
            r_is_attr    <= 1'b0;
            r_ma         <= '0;
            r_md_out     <= 8'h00;
            r_md_oe      <= 1'b0;
            r_cs_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_cpu_rdata  <= 8'h00;
            r_cpu_ack    <= 1'b0;
            r_vid_pix    <= 8'h00;
            r_vid_attr   <= 8'h00;
            r_vid_strobe <= 1'b0;
        end else begin
            r_cpu_ack    <= 1'b0;
            r_vid_strobe <= 1'b0;
            case (w_phase)
                c_PH_ADDR: begin
                    if (r_cnt == 4'd0) begin
                        r_vid_grp <= bus.vid_active;
                    end
                    r_busy    <= w_cpu_start || w_vid_start;
                    r_is_cpu  <= w_cpu_start;
                    r_is_wr   <= w_cpu_start && bus.cpu_we;
                    r_is_attr <= w_vid_start && (w_slot == 2'd1);
                    if (w_cpu_start) begin
                        r_ma <= bus.cpu_addr;
                        if (bus.cpu_we) begin
                            r_md_out <= bus.cpu_wdata;
                        end
                    end else if (w_vid_start) begin
                        r_ma <= w_vid_addr;
                    end
                    r_md_oe <= w_cpu_start && bus.cpu_we;
                    r_cs_n  <= !(w_cpu_start || w_vid_start);
                    r_we_n  <= !(w_cpu_start && bus.cpu_we);
                end
                c_PH_STB1: begin
                end
                c_PH_STB2: begin
                    // Strobes end here so phase 3 gives write data hold time.
                    r_cs_n <= 1'b1;
                    r_we_n <= 1'b1;
                    if (r_busy) begin
                        if (r_is_cpu) begin
                            r_cpu_ack <= 1'b1;
                            if (!r_is_wr) begin
                                r_cpu_rdata <= bus.md_in;
                            end
                        end else if (r_is_attr) begin
                            r_vid_attr   <= bus.md_in;
                            r_vid_strobe <= 1'b1;
                        end else begin
                            r_vid_pix <= bus.md_in;
                        end
                    end
                end
                c_PH_DONE: begin
                    r_holdoff <= r_busy && r_is_cpu;
                    r_busy    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ma         = r_ma;
    assign bus.md_out     = r_md_out;
    assign bus.md_oe      = r_md_oe;
    assign bus.cs_n       = r_cs_n;
    assign bus.we_n       = r_we_n;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.vid_pix    = r_vid_pix;
    assign bus.vid_attr   = r_vid_attr;
    assign bus.vid_strobe = r_vid_strobe;

endmodule
`default_nettype wire
